uart_fifo_transceiver: RTL

Parametrised full-duplex UART with independent TX and RX FIFOs, configurable parity mode and stop-bit count, and 16x-oversampled RX with mid-bit sampling. Valid/ready streaming interfaces on the parallel side. Sticky error flags for parity, framing and overrun. Serves as the reusable UART core for board-level wrappers (button/LED test tops, loopback rigs).

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_fifo_transceiver_sync_fifo.sv | 68 ++++++
 rtl/uart_fifo_transceiver.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART FIFO transceiver
// Contents:
//   parity_mode_e : NONE / EVEN / ODD parity selection
//   tx_state_e    : transmit engine states
//   rx_state_e    : receive engine states
//   calc_div      : clock cycles per oversample tick, truncated, never below 1
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_rate,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    int unsigned d;
    d = clk_rate / (baud_rate * oversample);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_fifo_transceiver_sync_fifo.sv
// rtl/uart_fifo_transceiver_sync_fifo.sv - first-word fall-through synchronous FIFO with level
// Ports:
//   clock, rst_n                     : clock, asynchronous active-low reset
//   push_data/push_valid/push_ready  : write side, transfer on valid && ready
//   pop_data/pop_valid/pop_ready     : read side, head visible while pop_valid (zero when empty)
//   level                            : occupancy 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     push_valid,
  output logic                     push_ready,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             full, empty, do_push, do_pop;

  // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign do_push    = push_valid && !full;
  assign do_pop     = pop_ready && !empty;
  assign pop_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign level      = wr_ptr_q - rd_ptr_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_fifo_transceiver.sv
// rtl/uart_fifo_transceiver.sv - full-duplex UART with TX/RX FIFOs, parity, 16x oversampled RX
// Ports:
//   clock, rst_n                   : system clock, asynchronous active-low reset
//   tx_data/tx_valid/tx_ready      : words into the TX FIFO
//   rx_data/rx_valid/rx_ready      : words out of the RX FIFO (first-word fall-through)
//   rx_in, tx_out                  : serial line in (asynchronous) and out (idle high)
//   tx_busy                        : TX engine not idle
//   tx_level, rx_level             : FIFO occupancies
//   err_clr                        : clears sticky flags (a same-cycle set wins)
//   parity_err, frame_err, overrun : sticky receive error flags
module uart_fifo_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_RATE    = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int WORD_WIDTH  = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [WORD_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [WORD_WIDTH-1:0]         rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic                          rx_in,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  input  logic                          err_clr,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int unsigned  DIV       = calc_div(CLK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int           CW        = $clog2(OVERSAMPLE);
  localparam int           BW        = $clog2(WORD_WIDTH);
  localparam parity_mode_e PMODE     = parity_mode_e'(PARITY_MODE[1:0]);
  localparam logic [31:0]  DIV_LAST  = 32'(DIV - 1);
  localparam logic [CW-1:0] OS_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  function automatic logic par_bit(input logic [WORD_WIDTH-1:0] d);
    return (PMODE == ODD) ? ~(^d) : ^d;
  endfunction

  // ---------------- tick generator ----------------
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic        sample_tick;

  assign sample_tick = (tick_cnt_q == DIV_LAST);
  always_comb tick_cnt_d = sample_tick ? '0 : tick_cnt_q + 32'd1;

  // ---------------- FIFOs ----------------
  logic [WORD_WIDTH-1:0] tx_fifo_data;
  logic                  tx_fifo_valid, tx_pop;
  logic                  rx_fifo_ready, rx_push;
  logic [WORD_WIDTH-1:0] rx_shift_q, rx_shift_d;

  sync_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock      (clock),
    .rst_n      (rst_n),
    .push_data  (tx_data),
    .push_valid (tx_valid),
    .push_ready (tx_ready),
    .pop_data   (tx_fifo_data),
    .pop_valid  (tx_fifo_valid),
    .pop_ready  (tx_pop),
    .level      (tx_level)
  );

  sync_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock      (clock),
    .rst_n      (rst_n),
    .push_data  (rx_shift_q),
    .push_valid (rx_push),
    .push_ready (rx_fifo_ready),
    .pop_data   (rx_data),
    .pop_valid  (rx_valid),
    .pop_ready  (rx_ready),
    .level      (rx_level)
  );

  // ---------------- TX engine ----------------
  tx_state_e             tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]         tx_bit_q, tx_bit_d;
  logic                  tx_stop_q, tx_stop_d;
  logic [WORD_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_out_q, tx_out_d;
  logic                  tx_bit_end;

  assign tx_bit_end = sample_tick && (tx_cnt_q == OS_LAST);
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign tx_out     = tx_out_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    tx_out_d   = 1'b1;

    if (sample_tick && (tx_state_q != TX_IDLE)) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
    end

    case (tx_state_q)
      TX_IDLE: begin
        if (sample_tick && tx_fifo_valid) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_fifo_data;
          tx_par_d   = par_bit(tx_fifo_data);
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == BIT_LAST) begin
            tx_stop_d  = 1'b0;
            tx_state_d = (PMODE == NONE) ? TX_STOP : TX_PARITY;
          end else begin
            tx_bit_d = tx_bit_q + BW'(1);
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_stop_d  = 1'b0;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_stop_q != STOP_LAST) begin
            tx_stop_d = 1'b1;
          end else if (tx_fifo_valid) begin
            // Back-to-back frames: reload straight into START, no idle bit.
            tx_pop     = 1'b1;
            tx_shift_d = tx_fifo_data;
            tx_par_d   = par_bit(tx_fifo_data);
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // The line level is registered from the next state so tx_out is glitch-free.
    case (tx_state_d)
      TX_START:  tx_out_d = 1'b0;
      TX_DATA:   tx_out_d = tx_shift_d[0];
      TX_PARITY: tx_out_d = tx_par_d;
      default:   tx_out_d = 1'b1;
    endcase
  end

  // ---------------- RX engine ----------------
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [BW-1:0] rx_bit_q, rx_bit_d;
  logic          rx_bad_q, rx_bad_d;
  logic          rx_s1_q, rx_s2_q;
  logic          rx_line, rx_mid;
  logic          set_par, set_frame, set_ovr;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  assign rx_line = rx_s2_q;
  assign rx_mid  = sample_tick && (rx_cnt_q == OS_LAST);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_bad_d   = rx_bad_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    set_par    = 1'b0;
    set_frame  = 1'b0;
    set_ovr    = 1'b0;

    if (sample_tick && (rx_state_q inside {RX_START, RX_DATA, RX_PARITY, RX_STOP})) begin
      rx_cnt_d = (rx_cnt_q == OS_LAST) ? '0 : rx_cnt_q + CW'(1);
    end

    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (sample_tick && !rx_line) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Half a bit after the falling edge: re-check the line to reject glitches,
        // then restart the count so every later sample lands mid-bit.
        if (sample_tick && (rx_cnt_q == HALF_LAST)) begin
          rx_cnt_d = '0;
          if (rx_line) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_bit_d   = '0;
            rx_bad_d   = 1'b0;
            rx_state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_mid) begin
          rx_shift_d = {rx_line, rx_shift_q[WORD_WIDTH-1:1]};
          if (rx_bit_q == BIT_LAST) begin
            rx_state_d = (PMODE == NONE) ? RX_STOP : RX_PARITY;
          end else begin
            rx_bit_d = rx_bit_q + BW'(1);
          end
        end
      end
      RX_PARITY: begin
        if (rx_mid) begin
          rx_bad_d   = (rx_line != par_bit(rx_shift_q));
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_mid) begin
          if (!rx_line) begin
            set_frame  = 1'b1;
            rx_state_d = RX_BREAK;
          end else begin
            rx_state_d = RX_IDLE;
            if (rx_bad_q) begin
              set_par = 1'b1;
            end else if (!rx_fifo_ready) begin
              set_ovr = 1'b1;
            end else begin
              rx_push = 1'b1;
            end
          end
        end
      end
      RX_BREAK: begin
        if (rx_line) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    parity_err_d = set_par   || (parity_err_q && !err_clr);
    frame_err_d  = set_frame || (frame_err_q  && !err_clr);
    overrun_d    = set_ovr   || (overrun_q    && !err_clr);
  end

  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

  // ---------------- state registers ----------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q   <= '0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_stop_q    <= 1'b0;
      tx_shift_q   <= '0;
      tx_par_q     <= 1'b0;
      tx_out_q     <= 1'b1;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_bad_q     <= 1'b0;
      rx_shift_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_stop_q    <= tx_stop_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_q     <= tx_par_d;
      tx_out_q     <= tx_out_d;
      rx_s1_q      <= rx_in;
      rx_s2_q      <= rx_s1_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_bad_q     <= rx_bad_d;
      rx_shift_q   <= rx_shift_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule
